// File: rtl/multichannel_pulse_duration_meter.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_pulse_duration_meter
// Description : Measures the width, in clock cycles, of pulses on several
//               asynchronous trigger inputs. Each completed pulse produces one
//               record (channel, duration, sequence number, saturation and
//               overrun flags) on a single valid/ready output stream.
//               Channels are served round-robin.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   system clock, all state on the rising edge
//   reset            in   asynchronous active-high reset, clears all state
//   trigger_in       in   raw asynchronous pulse inputs, one per channel
//   polarity         in   per channel: 0 = measure high pulses, 1 = low pulses
//   enable           in   0 = arm nothing new and abandon pulses in progress
//   result_valid     out  a record is presented
//   result_ready     in   consumer accepts the record when valid & ready
//   result_channel   out  channel index of the record
//   result_duration  out  active cycles of the pulse (saturating)
//   result_sequence  out  per-channel sequence number of the pulse
//   result_saturated out  duration reached the counter maximum
//   result_overrun   out  at least one earlier record of this channel was lost
// ============================================================================
module multichannel_pulse_duration_meter #(
  parameter int  NUM_CHANNELS  = 4,
  parameter int  COUNTER_WIDTH = 24,
  parameter int  SEQ_WIDTH     = 8,
  parameter int  SYNC_STAGES   = 2,
  localparam int CW            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CHANNELS-1:0]  trigger_in,
  input  logic [NUM_CHANNELS-1:0]  polarity,
  input  logic                     enable,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [CW-1:0]            result_channel,
  output logic [COUNTER_WIDTH-1:0] result_duration,
  output logic [SEQ_WIDTH-1:0]     result_sequence,
  output logic                     result_saturated,
  output logic                     result_overrun
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX    = '1;
  localparam int                       SETTLE_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0]            LAST_CHANNEL = CW'(NUM_CHANNELS - 1);

  // --------------------------------------------------------------------------
  // Settle counter: the synchronizer outputs only reflect the real inputs once
  // SYNC_STAGES edges have passed after reset. Until then no channel may decide
  // that its input is idle, so a pulse already active at reset release is
  // never mistaken for a fresh one.
  // --------------------------------------------------------------------------
  logic [SETTLE_W-1:0] settle_count;
  logic                settled;

  assign settled = (settle_count == SETTLE_W'(SYNC_STAGES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_count <= '0;
    end else if (!settled) begin
      settle_count <= settle_count + 1'b1;
    end
  end

  // Per-channel pending slots, gathered for the arbiter
  logic [NUM_CHANNELS-1:0]  pend_valid;
  logic [NUM_CHANNELS-1:0]  pend_sat;
  logic [NUM_CHANNELS-1:0]  pend_ovr;
  logic [COUNTER_WIDTH-1:0] pend_dur [NUM_CHANNELS];
  logic [SEQ_WIDTH-1:0]     pend_seq [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  drain;

  // --------------------------------------------------------------------------
  // Channel datapath: synchronizer, edge detect, duration counter, pending slot
  // --------------------------------------------------------------------------
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0]   sync_chain;
    logic                     active;
    logic                     active_d;
    logic                     start;
    logic                     stop;
    logic                     capture;
    logic                     armed;
    logic                     idle_seen;
    logic [COUNTER_WIDTH-1:0] count;
    logic [SEQ_WIDTH-1:0]     seq;
    logic                     slot_valid;
    logic                     slot_sat;
    logic                     slot_ovr;
    logic [COUNTER_WIDTH-1:0] slot_dur;
    logic [SEQ_WIDTH-1:0]     slot_seq;

    assign active  = sync_chain[SYNC_STAGES-1] ^ polarity[ch];
    assign start   = active & ~active_d;
    assign stop    = ~active & active_d;
    assign capture = stop & armed & enable;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync_chain <= '0;
        active_d   <= 1'b0;
        idle_seen  <= 1'b0;
        armed      <= 1'b0;
        count      <= '0;
        seq        <= '0;
      end else begin
        sync_chain <= {sync_chain[SYNC_STAGES-2:0], trigger_in[ch]};
        active_d   <= active;
        if (settled && !active) begin
          idle_seen <= 1'b1;
        end
        if (!enable) begin
          armed <= 1'b0;
          count <= '0;
        end else if (start) begin
          // A start edge only arms once the input has been seen idle after
          // reset; otherwise it is the tail of a pre-existing pulse.
          armed <= idle_seen;
          count <= idle_seen ? COUNTER_WIDTH'(1) : '0;
        end else if (armed) begin
          if (stop) begin
            armed <= 1'b0;
          end else if (count != COUNT_MAX) begin
            count <= count + 1'b1;
          end
        end
        // Counts every capture, overwritten ones included, so a consumer
        // sees gaps in the sequence when records are lost.
        if (capture) begin
          seq <= seq + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        slot_valid <= 1'b0;
        slot_sat   <= 1'b0;
        slot_ovr   <= 1'b0;
        slot_dur   <= '0;
        slot_seq   <= '0;
      end else if (capture) begin
        slot_valid <= 1'b1;
        slot_dur   <= count;
        slot_seq   <= seq;
        slot_sat   <= (count == COUNT_MAX);
        // Data still waiting and not leaving this cycle is about to be lost.
        slot_ovr   <= slot_valid & ~drain[ch];
      end else if (drain[ch]) begin
        slot_valid <= 1'b0;
      end
    end

    assign pend_valid[ch] = slot_valid;
    assign pend_sat[ch]   = slot_sat;
    assign pend_ovr[ch]   = slot_ovr;
    assign pend_dur[ch]   = slot_dur;
    assign pend_seq[ch]   = slot_seq;
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: search starts just after the last granted channel
  // --------------------------------------------------------------------------
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant_idx;
  logic [CW-1:0] cand_idx;
  logic          grant_found;
  logic          load_out;
  int            cand;

  assign load_out = ~result_valid | result_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cand = int'(last_grant) + 1 + i;
      if (cand >= NUM_CHANNELS) begin
        cand = cand - NUM_CHANNELS;
      end
      cand_idx = CW'(cand);
      if (!grant_found && pend_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    drain = '0;
    if (load_out && grant_found) begin
      drain[grant_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output register: reloads whenever empty or the current record is taken
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid     <= 1'b0;
      result_channel   <= '0;
      result_duration  <= '0;
      result_sequence  <= '0;
      result_saturated <= 1'b0;
      result_overrun   <= 1'b0;
      // Pointing at the last channel makes channel 0 the first one served.
      last_grant       <= LAST_CHANNEL;
    end else if (load_out) begin
      result_valid <= grant_found;
      if (grant_found) begin
        result_channel   <= grant_idx;
        result_duration  <= pend_dur[grant_idx];
        result_sequence  <= pend_seq[grant_idx];
        result_saturated <= pend_sat[grant_idx];
        result_overrun   <= pend_ovr[grant_idx];
        last_grant       <= grant_idx;
      end
    end
  end

endmodule
`default_nettype wire
